// File: rtl/sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// sar_search_ctrl
//
// Successive-approximation search controller. It drives the second operand
// (trial_o) of an external magnitude comparator whose first operand is an
// unknown target, and uses the comparator's greater/equal/lesser flags to
// recover the target one bit per cycle, MSB first.
//
// Ports
//   clk_i      : clock, all state updates on the rising edge
//   rst_i      : synchronous, active-high reset (priority over everything)
//   start_i    : request a new search, only looked at while idle
//   greater_i  : comparator flag, target >  trial_o
//   equal_i    : comparator flag, target == trial_o
//   lesser_i   : comparator flag, target <  trial_o
//   trial_o    : registered trial operand for the comparator
//   busy_o     : high in every search cycle
//   done_o     : one-cycle pulse when a search ends (normal or error)
//   result_o   : resolved value, valid from done_o until the next start
//   exact_o    : search ended on equal_i, held with result_o
//   error_o    : flags were not one-hot at a sample, held with result_o
//   state_o    : current FSM state (0 idle, 1 search, 2 done) for debug
//
// Handshake: start_i is a level request sampled only in IDLE; a start seen
// in SEARCH or DONE is dropped, not queued. Completion is the done_o pulse;
// there is no back-pressure, so result_o/exact_o/error_o are held steady
// until the next accepted start instead of requiring a consumer ready.
// ---------------------------------------------------------------------------
module sar_search_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             greater_i,
    input  logic             equal_i,
    input  logic             lesser_i,
    output logic [WIDTH-1:0] trial_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             exact_o,
    output logic             error_o,
    output logic [1:0]       state_o
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_BIT = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0]    K_TOP   = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] trial_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             exact_q;
    logic             error_q;

    // Next-step datapath, only consumed in SEARCH.
    logic             flags_onehot;
    logic             last_step;
    logic [WIDTH-1:0] acc_d;
    logic [KW-1:0]    k_d;
    logic [WIDTH-1:0] step_bit;
    logic [WIDTH-1:0] trial_d;

    always_comb begin
        flags_onehot = 1'b0;
        case ({greater_i, equal_i, lesser_i})
            3'b100, 3'b010, 3'b001: flags_onehot = 1'b1;
            default:                flags_onehot = 1'b0;
        endcase

        last_step = (k_q == '0);

        // greater keeps the trial bit by taking the whole trial (acc plus
        // bit k); lesser leaves acc alone, which drops bit k.
        acc_d = greater_i ? trial_q : acc_q;

        // Wraps to all ones when k_q is 0, but trial_d is unused then.
        k_d      = k_q - KW'(1);
        step_bit = LSB_BIT << k_d;

        // acc_d only holds bits above position k, so OR never carries.
        trial_d = acc_d | step_bit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            k_q      <= '0;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exact_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q  <= ST_SEARCH;
                        acc_q    <= '0;
                        k_q      <= K_TOP;
                        trial_q  <= MSB_BIT;
                        busy_q   <= 1'b1;
                        result_q <= '0;
                        exact_q  <= 1'b0;
                        error_q  <= 1'b0;
                    end
                end

                ST_SEARCH: begin
                    if (!flags_onehot) begin
                        // Broken comparator response: abandon the search.
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= '0;
                        exact_q  <= 1'b0;
                        error_q  <= 1'b1;
                    end else if (equal_i) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= trial_q;
                        exact_q  <= 1'b1;
                    end else if (last_step) begin
                        // LSB decided without an equal hit (only target 0).
                        state_q  <= ST_DONE;
                        acc_q    <= acc_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        exact_q  <= 1'b0;
                    end else begin
                        acc_q   <= acc_d;
                        k_q     <= k_d;
                        trial_q <= trial_d;
                    end
                end

                ST_DONE: begin
                    // start_i is ignored here; one full IDLE cycle follows.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    trial_q <= '0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    trial_q <= '0;
                end
            endcase
        end
    end

    assign trial_o  = trial_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign exact_o  = exact_q;
    assign error_o  = error_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
module tb_sar_search_ctrl;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i;
    logic         start_i;
    logic         greater_i;
    logic         equal_i;
    logic         lesser_i;
    logic [W-1:0] trial_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         exact_o;
    logic         error_o;
    logic [1:0]   state_o;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .greater_i (greater_i),
        .equal_i   (equal_i),
        .lesser_i  (lesser_i),
        .trial_o   (trial_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .exact_o   (exact_o),
        .error_o   (error_o),
        .state_o   (state_o)
    );

    // ---------------- behavioural comparator ----------------
    logic [W-1:0] target;
    int           cur_step;
    int           force_step;   // 0 = never force
    int           force_kind;   // 0 = greater+lesser high, 1 = all low

    always_comb begin
        greater_i = (target > trial_o);
        equal_i   = (target == trial_o);
        lesser_i  = (target < trial_o);
        if (force_step != 0 && cur_step == force_step && busy_o) begin
            if (force_kind == 0) begin
                greater_i = 1'b1;
                equal_i   = 1'b0;
                lesser_i  = 1'b1;
            end else begin
                greater_i = 1'b0;
                equal_i   = 1'b0;
                lesser_i  = 1'b0;
            end
        end
    end

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        logic [W-1:0] tgt;
        int           fstep;
        int           fkind;
        logic [W-1:0] e_res;
        logic         e_ex;
        logic         e_err;
        int           e_cyc;
    } vec_t;

    vec_t vecs[12];
    logic [W+1:0] exp_q[$];   // {error, exact, result}

    int n_vec  = 0;
    int n_chk  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Trial at step j: target bits above position W-j kept, bit W-j set,
    // everything below cleared.
    function automatic logic [W-1:0] model_trial(input logic [W-1:0] t, input int j);
        int b;
        logic [W-1:0] hi;
        logic [W-1:0] one;
        b   = W - j;
        one = 1;
        hi  = {W{1'b1}};
        hi  = hi << (b + 1);
        return (t & hi) | (one << b);
    endfunction

    // Expected outcome for a clean search of target t.
    function automatic vec_t model_vec(input logic [W-1:0] t);
        vec_t v;
        int   p;
        v.tgt = t; v.fstep = 0; v.fkind = 0;
        if (t == 0) begin
            v.e_res = '0; v.e_ex = 1'b0; v.e_err = 1'b0; v.e_cyc = W + 1;
        end else begin
            p = 0;
            while (t[p] == 1'b0) p++;
            v.e_res = t; v.e_ex = 1'b1; v.e_err = 1'b0; v.e_cyc = (W - p) + 1;
        end
        return v;
    endfunction

    // Follows a search whose start was accepted at the previous edge, until
    // done_o; then checks the idle cycle after it.
    task automatic follow(input vec_t v, input bit hold_start, input string tag);
        int           c;
        bit           seen;
        logic [W+1:0] e;
        c = 0;
        seen = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (!hold_start) start_i = 1'b0;
            if (done_o) begin
                seen = 1;
                e = exp_q.pop_front();
                check({tag, " done latency"}, c, v.e_cyc);
                check({tag, " result"}, result_o, e[W-1:0]);
                check({tag, " exact"}, exact_o, e[W]);
                check({tag, " error"}, error_o, e[W+1]);
                check({tag, " busy in done"}, busy_o, 0);
                check({tag, " state done"}, state_o, 2);
            end else begin
                check({tag, " busy"}, busy_o, 1);
                check({tag, " trial"}, trial_o, model_trial(v.tgt, c));
                cur_step = c;
            end
        end
        if (!seen) begin
            check({tag, " done timeout"}, 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
        check({tag, " idle state"}, state_o, 0);
        check({tag, " idle busy"}, busy_o, 0);
        check({tag, " idle done"}, done_o, 0);
        check({tag, " idle trial"}, trial_o, 0);
        check({tag, " result held"}, result_o, v.e_res);
    endtask

    task automatic start_and_follow(input vec_t v, input bit hold_start, input string tag);
        @(negedge clk);
        target     = v.tgt;
        force_step = v.fstep;
        force_kind = v.fkind;
        cur_step   = 0;
        start_i    = 1'b1;
        exp_q.push_back({v.e_err, v.e_ex, v.e_res});
        n_vec++;
        follow(v, hold_start, tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main ----------------
    initial begin
        vec_t v;
        int   c;
        bit   seen;

        vecs[0]  = '{8'hA5, 0, 0, 8'hA5, 1'b1, 1'b0, 9};
        vecs[1]  = '{8'h80, 0, 0, 8'h80, 1'b1, 1'b0, 2};
        vecs[2]  = '{8'h00, 0, 0, 8'h00, 1'b0, 1'b0, 9};
        vecs[3]  = '{8'hFF, 0, 0, 8'hFF, 1'b1, 1'b0, 9};
        vecs[4]  = '{8'h3C, 3, 0, 8'h00, 1'b0, 1'b1, 4};
        vecs[5]  = '{8'h3C, 3, 1, 8'h00, 1'b0, 1'b1, 4};
        vecs[6]  = '{8'h01, 0, 0, 8'h01, 1'b1, 1'b0, 9};
        vecs[7]  = '{8'h5A, 0, 0, 8'h5A, 1'b1, 1'b0, 8};
        vecs[8]  = '{8'hC0, 0, 0, 8'hC0, 1'b1, 1'b0, 3};
        vecs[9]  = '{8'h55, 1, 1, 8'h00, 1'b0, 1'b1, 2};
        vecs[10] = '{8'h00, 8, 0, 8'h00, 1'b0, 1'b1, 9};
        vecs[11] = '{8'h3C, 0, 0, 8'h3C, 1'b1, 1'b0, 7};

        rst_i = 1'b1; start_i = 1'b0; target = '0;
        cur_step = 0; force_step = 0; force_kind = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        check("reset trial", trial_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset result", result_o, 0);
        check("reset exact", exact_o, 0);
        check("reset error", error_o, 0);
        check("reset state", state_o, 0);

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            start_and_follow(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // start_i held high for a whole search: no restart while busy, then
        // the next search begins from the idle cycle after done_o.
        start_and_follow(vecs[0], 1'b1, "hold");
        exp_q.push_back({vecs[0].e_err, vecs[0].e_ex, vecs[0].e_res});
        n_vec++;
        cur_step = 0;
        follow(vecs[0], 1'b0, "hold restart");

        // Reset at step 4: everything clears, no done_o for the aborted run.
        @(negedge clk);
        n_vec++;
        target = 8'h5A; force_step = 0; cur_step = 0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("abort trial step4", trial_o, model_trial(8'h5A, 4));
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("abort trial", trial_o, 0);
        check("abort busy", busy_o, 0);
        check("abort done", done_o, 0);
        check("abort result", result_o, 0);
        check("abort exact", exact_o, 0);
        check("abort error", error_o, 0);
        check("abort state", state_o, 0);
        seen = 0;
        for (c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        check("abort no done", seen, 0);
        start_and_follow(vecs[7], 1'b0, "after abort");

        // Random targets against the model.
        for (int r = 0; r < 8; r++) begin
            v = model_vec(W'($urandom_range(0, 255)));
            start_and_follow(v, 1'b0, $sformatf("rand%0d", r));
        end

        check("scoreboard empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
